// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - refill engine states, AXI read constants and default cache geometry
package if_pkg;

  localparam int WAYS      = 2;
  localparam int NUM_SETS  = 512;
  localparam int BLK_WORDS = 8;
  localparam int SET_BITS  = $clog2(NUM_SETS);
  localparam int OFF_BITS  = $clog2(BLK_WORDS);
  localparam int BYTE_BITS = 3;
  localparam int LINE_LSB  = OFF_BITS + BYTE_BITS;
  localparam int TAG_BITS  = 64 - SET_BITS - LINE_LSB;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_8B    = 3'b011;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [7:0] AR_LEN     = 8'(BLK_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_COMMIT,
    S_COOL
  } refill_state_e;

  // Fill an invalid way first; with both ways valid the LRU bit names the victim.
  function automatic logic pick_victim(input logic [WAYS-1:0] valid, input logic lru);
    if (!valid[0])      return 1'b0;
    else if (!valid[1]) return 1'b1;
    else                return lru;
  endfunction

endpackage

// File: rtl/if_refill.sv
// rtl/if_refill.sv - instruction-cache miss service: one INCR burst per block, then valid/tag commit
module if_refill
  import if_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  IF_miss,
  input  logic [63:0]           IF_addr,
  input  logic [WAYS-1:0]       way_valid,
  input  logic                  lru_in,
  output logic [SET_BITS-1:0]   lookup_set,
  output logic [63:0]           m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [63:0]           m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic                  fill_we,
  output logic [SET_BITS-1:0]   fill_set,
  output logic                  fill_way,
  output logic [OFF_BITS-1:0]   fill_word,
  output logic [63:0]           fill_data,
  output logic                  tag_we,
  output logic [TAG_BITS:0]     tag_wdata,
  output logic                  refill_done,
  output logic                  refill_err,
  output logic                  busy
);

  refill_state_e         state;
  logic [SET_BITS-1:0]   set_q;
  logic [TAG_BITS-1:0]   tag_q;
  logic                  way_q;
  logic [OFF_BITS-1:0]   cnt;
  logic                  err_q;
  logic                  beat;
  logic                  last_cnt;
  logic                  beat_err;
  logic                  err_next;
  logic                  unused_addr_bits;

  assign m_axi_arlen   = AR_LEN;
  assign m_axi_arsize  = SIZE_8B;
  assign m_axi_arburst = BURST_INCR;

  assign beat     = m_axi_rready & m_axi_rvalid;
  assign last_cnt = (cnt == OFF_BITS'(BLK_WORDS - 1));
  // The beat counter decides the end of the burst; rlast only has to agree with it.
  assign beat_err = (m_axi_rresp != RESP_OKAY) | (m_axi_rlast != last_cnt);
  assign err_next = err_q | beat_err;

  assign lookup_set = (state == S_IDLE) ? IF_addr[LINE_LSB +: SET_BITS] : set_q;
  assign fill_we    = beat;
  assign fill_set   = set_q;
  assign fill_way   = way_q;
  assign fill_word  = cnt;
  assign fill_data  = beat ? m_axi_rdata : '0;
  assign busy       = (state != S_IDLE);

  assign unused_addr_bits = ^IF_addr[LINE_LSB-1:0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      set_q         <= '0;
      tag_q         <= '0;
      way_q         <= 1'b0;
      cnt           <= '0;
      err_q         <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      tag_we        <= 1'b0;
      tag_wdata     <= '0;
      refill_done   <= 1'b0;
      refill_err    <= 1'b0;
    end else begin
      tag_we      <= 1'b0;
      tag_wdata   <= '0;
      refill_done <= 1'b0;
      refill_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (IF_miss) begin
            m_axi_araddr  <= {IF_addr[63:LINE_LSB], {LINE_LSB{1'b0}}};
            set_q         <= IF_addr[LINE_LSB +: SET_BITS];
            tag_q         <= IF_addr[63 -: TAG_BITS];
            way_q         <= pick_victim(way_valid, lru_in);
            m_axi_arvalid <= 1'b1;
            state         <= S_AR;
          end
        end
        S_AR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            cnt           <= '0;
            err_q         <= 1'b0;
            state         <= S_R;
          end
        end
        S_R: begin
          if (beat) begin
            cnt   <= cnt + OFF_BITS'(1);
            err_q <= err_next;
            if (last_cnt) begin
              m_axi_rready <= 1'b0;
              tag_we       <= ~err_next;
              tag_wdata    <= err_next ? '0 : {1'b1, tag_q};
              refill_done  <= ~err_next;
              refill_err   <= err_next;
              state        <= S_COMMIT;
            end
          end
        end
        S_COMMIT: state <= S_COOL;
        S_COOL:   state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule
